// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the rv32i pipeline: per-register load and
// bubble enables, per-stage validity, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 3,
    parameter int REGW       = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_stall,
    input  logic                  dcache_stall,
    input  logic [REGW-1:0]       id_rs1,
    input  logic [REGW-1:0]       id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REGW-1:0]       ex_rd,
    input  logic                  ex_is_load,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stage_load,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [CNT_W-1:0]      retire_count
);

    localparam int PCW = $clog2(NUM_STAGES + 1);

    logic                  redirect_q;
    logic                  luse;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  redirect_eff;
    logic                  any_hold;
    logic                  retire_en;
    logic [PCW-1:0]        squash_cnt;
    logic [NUM_STAGES-1:0] valid_nxt;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign redirect_q = redirect & stage_valid[BR_STAGE];

    assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);

    assign luse = ex_is_load & stage_valid[2] & stage_valid[1]
                & (ex_rd != '0) & (rs1_hit | rs2_hit);

    // A frozen pipe ignores redirect; its source holds it until the freeze ends
    assign redirect_eff = redirect_q & ~dcache_stall;

    always_comb begin
        stage_load  = '1;
        stage_flush = '0;
        if (rst) begin
            if (dcache_stall) begin
                stage_load = '0;
            end else if (redirect_q) begin
                for (int i = 1; i <= BR_STAGE; i++) begin
                    stage_flush[i] = 1'b1;
                end
            end else if (luse) begin
                stage_load[0]  = 1'b0;
                stage_load[1]  = 1'b0;
                stage_flush[2] = 1'b1;
            end else if (icache_stall) begin
                stage_load[0]  = 1'b0;
                stage_flush[1] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_nxt    = stage_valid;
        valid_nxt[0] = 1'b1;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (stage_flush[i]) begin
                valid_nxt[i] = 1'b0;
            end else if (stage_load[i]) begin
                valid_nxt[i] = stage_valid[i-1];
            end
        end
    end

    always_comb begin
        squash_cnt = '0;
        for (int i = 1; i <= BR_STAGE; i++) begin
            squash_cnt = squash_cnt + PCW'(stage_valid[i]);
        end
    end

    assign any_hold  = ~(&stage_load);
    assign retire_en = stage_valid[NUM_STAGES-1] & ~dcache_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid  <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
            retire_count <= '0;
        end else begin
            stage_valid <= valid_nxt;
            if (any_hold) begin
                stall_cycles <= sat_add(stall_cycles, CNT_W'(1));
            end
            if (redirect_eff) begin
                flush_count <= sat_add(flush_count, CNT_W'(squash_cnt));
            end
            if (retire_en) begin
                retire_count <= sat_add(retire_count, CNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 32-bit counter build and a
// 4-bit counter build share stimulus so saturation can be observed.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       icache_stall = 1'b0;
    logic       dcache_stall = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs1 = 1'b0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_is_load = 1'b0;
    logic       redirect = 1'b0;

    logic [4:0]  stage_load, stage_flush, stage_valid;
    logic [31:0] stall_cycles, flush_count, retire_count;
    logic [4:0]  s_load, s_flush, s_valid;
    logic [3:0]  s_stall, s_flush_cnt, s_retire;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NUM_STAGES(5), .BR_STAGE(3), .REGW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .redirect(redirect),
        .stage_load(stage_load), .stage_flush(stage_flush),
        .stage_valid(stage_valid), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .retire_count(retire_count)
    );

    pipe_hazard_ctrl #(.NUM_STAGES(5), .BR_STAGE(3), .REGW(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .redirect(redirect),
        .stage_load(s_load), .stage_flush(s_flush),
        .stage_valid(s_valid), .stall_cycles(s_stall),
        .flush_count(s_flush_cnt), .retire_count(s_retire)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] ld,
                           input logic [4:0] fl);
        chk({tag, "_load"}, 32'(stage_load), 32'(ld));
        chk({tag, "_flush"}, 32'(stage_flush), 32'(fl));
    endtask

    initial begin
        #2;
        chk_ctl("rst", 5'b11111, 5'b00000);
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // edges 0..10 after release: fill then retire on edges 5..10
        tick(1);
        chk("fill_v0", 32'(stage_valid), 32'b00001);
        tick(4);
        chk("fill_v4", 32'(stage_valid), 32'b11111);
        tick(6);
        chk("idle_retire", retire_count, 32'd6);
        chk("idle_stall", stall_cycles, 32'd0);

        redirect = 1'b1;
        #1;
        chk_ctl("redir", 5'b11111, 5'b01110);
        tick(1);
        redirect = 1'b0;
        chk("redir_v1", 32'(stage_valid), 32'b10001);
        chk("redir_fcnt", flush_count, 32'd3);
        tick(1);
        chk("redir_v2", 32'(stage_valid), 32'b00011);
        tick(3);
        chk("redir_refill", 32'(stage_valid), 32'b11111);
        chk("redir_retire", retire_count, 32'd8);

        ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        chk_ctl("luse", 5'b11100, 5'b00100);
        tick(1);
        chk("luse_v", 32'(stage_valid), 32'b11011);
        chk_ctl("luse_once", 5'b11111, 5'b00000);
        chk("luse_stall", stall_cycles, 32'd1);
        ex_is_load = 1'b0;
        tick(3);
        chk("luse_refill", 32'(stage_valid), 32'b11111);
        chk("luse_retire", retire_count, 32'd11);
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk_ctl("luse_x0", 5'b11111, 5'b00000);
        tick(1);
        chk("luse_x0_stall", stall_cycles, 32'd1);

        ex_rd = 5'd5; id_rs2 = 5'd5;
        redirect = 1'b1; dcache_stall = 1'b1;
        #1;
        chk_ctl("frz", 5'b00000, 5'b00000);
        tick(4);
        chk("frz_valid", 32'(stage_valid), 32'b11111);
        chk("frz_stall", stall_cycles, 32'd5);
        chk("frz_retire", retire_count, 32'd12);
        chk("frz_fcnt", flush_count, 32'd3);
        dcache_stall = 1'b0;
        #1;
        chk_ctl("frz_end", 5'b11111, 5'b01110);
        tick(1);
        redirect = 1'b0; ex_is_load = 1'b0;
        chk("frz_v", 32'(stage_valid), 32'b10001);
        chk("frz_fcnt2", flush_count, 32'd6);
        tick(4);
        chk("frz_refill", 32'(stage_valid), 32'b11111);

        icache_stall = 1'b1;
        #1;
        chk_ctl("ic1", 5'b11110, 5'b00010);
        tick(1);
        chk("ic1_v", 32'(stage_valid), 32'b11101);
        redirect = 1'b1;
        #1;
        chk_ctl("ic2_redir", 5'b11111, 5'b01110);
        tick(1);
        redirect = 1'b0;
        chk("ic2_v", 32'(stage_valid), 32'b10001);
        chk("ic2_fcnt", flush_count, 32'd8);
        #1;
        chk_ctl("ic3", 5'b11110, 5'b00010);
        tick(1);
        chk("ic3_v", 32'(stage_valid), 32'b00001);
        chk("ic_retire", retire_count, 32'd17);
        chk("ic_stall", stall_cycles, 32'd7);
        icache_stall = 1'b0;
        tick(4);

        dcache_stall = 1'b1;
        tick(20);
        dcache_stall = 1'b0;
        chk("sat_big_stall", stall_cycles, 32'd27);
        chk("sat_small_stall", 32'(s_stall), 32'd15);
        chk("sat_small_retire", 32'(s_retire), 32'd15);
        chk("sat_small_fcnt", 32'(s_flush_cnt), 32'd8);

        redirect = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(stage_valid), 32'h0);
        chk("mid_rst_stall", stall_cycles, 32'd0);
        chk("mid_rst_fcnt", flush_count, 32'd0);
        chk_ctl("mid_rst", 5'b11111, 5'b00000);
        redirect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
